// File: rtl/gf180mcu_fd_io__pwrseq.sv
// Power-up sequencer for the gf180mcu IO ring: debounces the IO and core supply flags,
// releases core/pad isolation, enables pad inputs, then gates pad outputs under software control.
module gf180mcu_fd_io__pwrseq #(
   parameter int DBNC   = 255,
   parameter int SETTLE = 15,
   parameter int W      = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic DVDD_OK,
   input  logic VDD_OK,
   input  logic SW_EN,
   input  logic FAULT_CLR,
   output logic ISO,
   output logic PAD_IE_EN,
   output logic PAD_OE_EN,
   output logic READY,
   output logic FAULT
);

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_DBNC_IO   = 3'd1,
      ST_DBNC_CORE = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_STANDBY   = 3'd4,
      ST_ACTIVE    = 3'd5,
      ST_FAULT     = 3'd6
   } state_t;

   // Terminal counts: a state holding for N cycles exits when the counter reads N-1.
   localparam logic [W-1:0] DBNC_LAST   = W'(DBNC - 1);
   localparam logic [W-1:0] SETTLE_LAST = W'(SETTLE - 1);
   localparam logic [W-1:0] CNT_ONE     = W'(1);

   state_t         state_r;
   state_t         state_nxt_s;
   logic [W-1:0]   cnt_r;
   logic [W-1:0]   cnt_nxt_s;
   logic           dv_meta_r;
   logic           dv_sync_r;
   logic           vd_meta_r;
   logic           vd_sync_r;
   logic           supply_ok_s;
   logic [4:0]     out_nxt_s;
   logic [4:0]     out_r;

   assign supply_ok_s = dv_sync_r & vd_sync_r;

   // Two-flop synchronizers for the asynchronous supply-good flags.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dv_meta_r <= 1'b0;
         dv_sync_r <= 1'b0;
         vd_meta_r <= 1'b0;
         vd_sync_r <= 1'b0;
      end else begin
         dv_meta_r <= DVDD_OK;
         dv_sync_r <= dv_meta_r;
         vd_meta_r <= VDD_OK;
         vd_sync_r <= vd_meta_r;
      end
   end

   // State and shared counter registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= ST_OFF;
         cnt_r   <= {W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state logic; the counter defaults to zero so every transition clears it.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = {W{1'b0}};
      case (state_r)
         ST_OFF: begin
            if (dv_sync_r) state_nxt_s = ST_DBNC_IO;
            else           state_nxt_s = ST_OFF;
         end
         ST_DBNC_IO: begin
            if (!dv_sync_r)              state_nxt_s = ST_OFF;
            else if (cnt_r == DBNC_LAST) state_nxt_s = ST_DBNC_CORE;
            else                         cnt_nxt_s   = cnt_r + CNT_ONE;
         end
         ST_DBNC_CORE: begin
            if (!dv_sync_r)              state_nxt_s = ST_OFF;
            else if (!vd_sync_r)         cnt_nxt_s   = {W{1'b0}};
            else if (cnt_r == DBNC_LAST) state_nxt_s = ST_SETTLE;
            else                         cnt_nxt_s   = cnt_r + CNT_ONE;
         end
         ST_SETTLE: begin
            if (!supply_ok_s)              state_nxt_s = ST_FAULT;
            else if (cnt_r == SETTLE_LAST) state_nxt_s = ST_STANDBY;
            else                           cnt_nxt_s   = cnt_r + CNT_ONE;
         end
         ST_STANDBY: begin
            if (!supply_ok_s) state_nxt_s = ST_FAULT;
            else if (SW_EN)   state_nxt_s = ST_ACTIVE;
            else              state_nxt_s = ST_STANDBY;
         end
         ST_ACTIVE: begin
            if (!supply_ok_s) state_nxt_s = ST_FAULT;
            else if (!SW_EN)  state_nxt_s = ST_STANDBY;
            else              state_nxt_s = ST_ACTIVE;
         end
         ST_FAULT: begin
            if (FAULT_CLR) state_nxt_s = ST_OFF;
            else           state_nxt_s = ST_FAULT;
         end
         default: begin
            state_nxt_s = ST_OFF;
         end
      endcase
   end

   // Output decode of the next state: {ISO, IE, OE, READY, FAULT}.
   always_comb begin
      out_nxt_s = 5'b10000;
      case (state_nxt_s)
         ST_OFF:       out_nxt_s = 5'b10000;
         ST_DBNC_IO:   out_nxt_s = 5'b10000;
         ST_DBNC_CORE: out_nxt_s = 5'b10000;
         ST_SETTLE:    out_nxt_s = 5'b00000;
         ST_STANDBY:   out_nxt_s = 5'b01010;
         ST_ACTIVE:    out_nxt_s = 5'b01110;
         ST_FAULT:     out_nxt_s = 5'b10001;
         default:      out_nxt_s = 5'b10000;
      endcase
   end

   // Output flops load with the state register so pads never see decode glitches.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) out_r <= 5'b10000;
      else     out_r <= out_nxt_s;
   end

   assign ISO       = out_r[4];
   assign PAD_IE_EN = out_r[3];
   assign PAD_OE_EN = out_r[2];
   assign READY     = out_r[1];
   assign FAULT     = out_r[0];

endmodule

// File: tb/tb_gf180mcu_fd_io__pwrseq.sv
// Randomized self-checking bench for the power sequencer: two instances (DBNC=4 and DBNC=8, W=3)
// compared every cycle against a phase/remaining-time reference model.
module tb_gf180mcu_fd_io__pwrseq;

   logic CLK = 1'b0;
   logic RST, DVDD_OK, VDD_OK, SW_EN, FAULT_CLR;
   logic iso_a, ie_a, oe_a, rdy_a, flt_a;
   logic iso_b, ie_b, oe_b, rdy_b, flt_b;

   int vectors = 0;
   int miscompares = 0;
   int edge_n = 0;

   always #5 CLK = ~CLK;

   gf180mcu_fd_io__pwrseq #(.DBNC(4), .SETTLE(2), .W(3)) dut_a (
      .CLK(CLK), .RST(RST), .DVDD_OK(DVDD_OK), .VDD_OK(VDD_OK), .SW_EN(SW_EN),
      .FAULT_CLR(FAULT_CLR), .ISO(iso_a), .PAD_IE_EN(ie_a), .PAD_OE_EN(oe_a),
      .READY(rdy_a), .FAULT(flt_a));

   gf180mcu_fd_io__pwrseq #(.DBNC(8), .SETTLE(2), .W(3)) dut_b (
      .CLK(CLK), .RST(RST), .DVDD_OK(DVDD_OK), .VDD_OK(VDD_OK), .SW_EN(SW_EN),
      .FAULT_CLR(FAULT_CLR), .ISO(iso_b), .PAD_IE_EN(ie_b), .PAD_OE_EN(oe_b),
      .READY(rdy_b), .FAULT(flt_b));

   // Reference model: phase plus cycles remaining in it, synchronizer as a 2-deep delay line.
   localparam int P_OFF = 0, P_IO = 1, P_CORE = 2, P_SETTLE = 3, P_STBY = 4, P_ACT = 5, P_FAULT = 6;
   int   ph [2];
   int   rem [2];
   int   dbnc_len [2] = '{4, 8};
   int   settle_len = 2;
   logic dv_pipe [2];
   logic vd_pipe [2];

   task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @edge %0d: got %b expected %b", tag, edge_n, got, exp);
      end
   endtask

   function automatic logic [4:0] exp_out(input int p);
      case (p)
         P_SETTLE: return 5'b00000;
         P_STBY:   return 5'b01010;
         P_ACT:    return 5'b01110;
         P_FAULT:  return 5'b10001;
         default:  return 5'b10000;
      endcase
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         ph[m] = P_OFF;
         rem[m] = 0;
      end
      dv_pipe = '{1'b0, 1'b0};
      vd_pipe = '{1'b0, 1'b0};
   endtask

   task automatic model_edge();
      logic dv, vd;
      dv = dv_pipe[1];
      vd = vd_pipe[1];
      for (int m = 0; m < 2; m++) begin
         case (ph[m])
            P_OFF: if (dv) begin ph[m] = P_IO; rem[m] = dbnc_len[m]; end
            P_IO: begin
               if (!dv) ph[m] = P_OFF;
               else if (rem[m] == 1) begin ph[m] = P_CORE; rem[m] = dbnc_len[m]; end
               else rem[m]--;
            end
            P_CORE: begin
               if (!dv) ph[m] = P_OFF;
               else if (!vd) rem[m] = dbnc_len[m];
               else if (rem[m] == 1) begin ph[m] = P_SETTLE; rem[m] = settle_len; end
               else rem[m]--;
            end
            P_SETTLE: begin
               if (!(dv && vd)) ph[m] = P_FAULT;
               else if (rem[m] == 1) ph[m] = P_STBY;
               else rem[m]--;
            end
            P_STBY:  if (!(dv && vd)) ph[m] = P_FAULT; else if (SW_EN) ph[m] = P_ACT;
            P_ACT:   if (!(dv && vd)) ph[m] = P_FAULT; else if (!SW_EN) ph[m] = P_STBY;
            P_FAULT: if (FAULT_CLR) ph[m] = P_OFF;
            default: ph[m] = P_OFF;
         endcase
      end
      dv_pipe[1] = dv_pipe[0];
      dv_pipe[0] = DVDD_OK;
      vd_pipe[1] = vd_pipe[0];
      vd_pipe[0] = VDD_OK;
   endtask

   // One clock: advance the model at the rising edge, compare both instances at the falling edge.
   task automatic cycle();
      @(posedge CLK);
      if (RST) model_reset();
      else begin
         edge_n++;
         model_edge();
      end
      @(negedge CLK);
      chk("outs_dbnc4", {iso_a, ie_a, oe_a, rdy_a, flt_a}, exp_out(ph[0]));
      chk("outs_dbnc8", {iso_b, ie_b, oe_b, rdy_b, flt_b}, exp_out(ph[1]));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      RST = 1'b1;
      model_reset();
      run(3);
      RST = 1'b0;
      edge_n = 0;
   endtask

   task automatic async_reset_check();
      #2;
      RST = 1'b1;
      #1;
      chk("async_rst_a", {iso_a, ie_a, oe_a, rdy_a, flt_a}, 5'b10000);
      chk("async_rst_b", {iso_b, ie_b, oe_b, rdy_b, flt_b}, 5'b10000);
      do_reset();
   endtask

   int dv_low, vd_low;

   initial begin
      DVDD_OK = 1'b0; VDD_OK = 1'b0; SW_EN = 1'b0; FAULT_CLR = 1'b0;
      do_reset();

      // Clean power-up with exact edge checks.
      DVDD_OK = 1'b1; VDD_OK = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         cycle();
         if (e == 10) chk("iso_before_11", {4'b0000, iso_a}, 5'b00001);
         if (e == 11) chk("iso_after_11", {4'b0000, iso_a}, 5'b00000);
         if (e == 12) chk("ready_before_13", {4'b0000, rdy_a}, 5'b00000);
         if (e == 13) chk("ready_ie_after_13", {3'b000, rdy_a, ie_a}, 5'b00011);
         if (e == 20) chk("dbnc8_ready_before_21", {4'b0000, rdy_b}, 5'b00000);
         if (e == 21) chk("dbnc8_ready_after_21", {4'b0000, rdy_b}, 5'b00001);
      end
      chk("oe_idle", {4'b0000, oe_a}, 5'b00000);

      // Output enable both directions, one cycle each.
      SW_EN = 1'b1; cycle();
      chk("oe_on", {3'b000, oe_a, rdy_a}, 5'b00011);
      SW_EN = 1'b0; cycle();
      chk("oe_off", {3'b000, oe_a, rdy_a}, 5'b00001);

      // Brown-out in ACTIVE: fault exactly 3 cycles after the drop.
      SW_EN = 1'b1; run(2);
      VDD_OK = 1'b0; run(2);
      chk("brownout_early", {4'b0000, flt_a}, 5'b00000);
      cycle();
      chk("brownout_fault", {iso_a, ie_a, oe_a, rdy_a, flt_a}, 5'b10001);
      VDD_OK = 1'b1; SW_EN = 1'b0; run(3);
      FAULT_CLR = 1'b1; cycle();
      chk("fault_clr", {4'b0000, flt_a}, 5'b00000);
      FAULT_CLR = 1'b0; run(30);

      // Async reset from ACTIVE, then debounce glitch on a fresh power-up.
      SW_EN = 1'b1; run(3);
      async_reset_check();
      SW_EN = 1'b0;
      run(4);
      DVDD_OK = 1'b0; run(2);
      DVDD_OK = 1'b1; run(30);

      // Randomized supply drops, software enables, fault clears and occasional resets.
      dv_low = 0; vd_low = 0;
      for (int i = 0; i < 2000; i++) begin
         if (dv_low == 0 && $urandom_range(0, 59) == 0) dv_low = $urandom_range(1, 5);
         if (vd_low == 0 && $urandom_range(0, 49) == 0) vd_low = $urandom_range(1, 5);
         DVDD_OK = (dv_low == 0);
         VDD_OK = (vd_low == 0);
         if (dv_low > 0) dv_low--;
         if (vd_low > 0) vd_low--;
         if ($urandom_range(0, 9) == 0) SW_EN = ~SW_EN;
         FAULT_CLR = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 399) == 0) async_reset_check();
         else cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
